// File: rtl/ahb_apb_pkg.sv
// Shared types and helpers for the AHB-lite to APB4 bridge.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    SETUP,
    ACCESS,
    DONE,
    ERR1,
    ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Byte lanes touched by a write of the given size at the given byte offset.
  function automatic logic [3:0] pstrb_gen(input logic [2:0] hsize, input logic [1:0] addr);
    case (hsize)
      3'd0:    pstrb_gen = 4'(4'b0001 << addr);
      3'd1:    pstrb_gen = 4'(4'b0011 << {addr[1], 1'b0});
      default: pstrb_gen = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] hsize, input logic [1:0] addr);
    is_misaligned = ((hsize == 3'd1) && addr[0]) ||
                    ((hsize == 3'd2) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating count of APB ACCESS cycles; flags expiry when the count equals TIMEOUT.
module apb_timeout_cnt #(
  parameter int unsigned TOW     = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam logic [TOW-1:0] CNT_MAX = '1;
  localparam logic [TOW-1:0] TO_VAL  = TOW'(TIMEOUT);
  localparam bit             TO_EN   = (TIMEOUT != 0);

  logic [TOW-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + TOW'(1);
    end
  end

  assign expired_c = TO_EN && (cnt_q == TO_VAL);

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-lite slave to APB4 master bridge: one APB SETUP/ACCESS pair per accepted
// AHB transfer, with APB errors and pready timeouts mapped to a two-cycle ERROR.
module ahb_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TOW     = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [3:0]    hprot,
  input  logic          hreadym,
  input  logic [DW-1:0] hwdata,
  output logic          hready,
  output logic          hresp,
  output logic [DW-1:0] hrdata,
  output logic          psel,
  output logic          penable,
  output logic [AW-1:0] paddr,
  output logic          pwrite,
  output logic [DW-1:0] pwdata,
  output logic [3:0]    pstrb,
  output logic [2:0]    pprot,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  if (DW != 32) begin : g_bad_dw
    $error("ahb_apb_bridge: DW must be 32");
  end
  if ((64'(TIMEOUT) >> TOW) != 64'd0) begin : g_bad_timeout
    $error("ahb_apb_bridge: TIMEOUT does not fit in TOW bits");
  end

  state_t state_q, state_d;
  logic   trans_act_c;
  logic   accept_c;
  logic   bad_c;
  logic   tmo_c;
  logic   cnt_clr_c;
  logic   cnt_en_c;
  logic   unused_ok;

  assign unused_ok = ^hprot[3:2];

  always_comb begin
    trans_act_c = 1'b0;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: trans_act_c = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  trans_act_c = 1'b0;
      default:                   trans_act_c = 1'b0;
    endcase
  end

  assign accept_c = hsel && trans_act_c && hreadym && hready;
  assign bad_c    = (hsize > 3'd2) || is_misaligned(hsize, haddr[1:0]);

  // Counter restarts on entry to SETUP, so during the k-th ACCESS cycle it reads k.
  assign cnt_clr_c = (state_d == SETUP);
  assign cnt_en_c  = (state_d == ACCESS);

  apb_timeout_cnt #(
    .TOW     (TOW),
    .TIMEOUT (TIMEOUT)
  ) u_tcnt (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (cnt_clr_c),
    .en        (cnt_en_c),
    .expired_c (tmo_c)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR2: begin
        if (accept_c) begin
          if (bad_c)       state_d = ERR1;
          else if (hwrite) state_d = WDATA;
          else             state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      WDATA:  state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (pready)     state_d = pslverr ? ERR1 : DONE;
        else if (tmo_c) state_d = ERR1;
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are a registered decode of the next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      hready  <= 1'b1;
      hresp   <= 1'b0;
      hrdata  <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      paddr   <= '0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
      pstrb   <= 4'b0000;
      pprot   <= 3'b000;
    end else begin
      state_q <= state_d;
      psel    <= (state_d == SETUP) || (state_d == ACCESS);
      penable <= (state_d == ACCESS);
      hready  <= (state_d == IDLE) || (state_d == DONE) || (state_d == ERR2);
      hresp   <= (state_d == ERR1) || (state_d == ERR2);
      if (accept_c) begin
        paddr  <= haddr;
        pwrite <= hwrite;
        pstrb  <= hwrite ? pstrb_gen(hsize, haddr[1:0]) : 4'b0000;
        pprot  <= {~hprot[0], 1'b0, hprot[1]};
      end
      if (state_q == WDATA) begin
        pwdata <= hwdata;
      end
      if ((state_q == ACCESS) && pready && !pslverr && !pwrite) begin
        hrdata <= prdata;
      end
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed self-checking bench for ahb_apb_bridge (default instance plus a TIMEOUT=4 instance).
module tb_ahb_apb_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        hsel, hsel_to;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic        hreadym;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;

  logic        hready, hresp, psel, penable, pwrite;
  logic [31:0] hrdata, paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  logic        hready_to, hresp_to, psel_to, penable_to, pwrite_to;
  logic [31:0] hrdata_to, paddr_to, pwdata_to;
  logic [3:0]  pstrb_to;
  logic [2:0]  pprot_to;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ahb_apb_bridge u_dut (
    .clk(clk), .resetn(resetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hreadym(hreadym), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata), .psel(psel), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  ahb_apb_bridge #(.TIMEOUT(4)) u_dut_to (
    .clk(clk), .resetn(resetn), .hsel(hsel_to), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hreadym(hreadym), .hwdata(hwdata),
    .hready(hready_to), .hresp(hresp_to), .hrdata(hrdata_to), .psel(psel_to),
    .penable(penable_to), .paddr(paddr_to), .pwrite(pwrite_to), .pwdata(pwdata_to),
    .pstrb(pstrb_to), .pprot(pprot_to), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [31:0] a, input logic w, input logic [2:0] s,
                            input logic [3:0] p);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = w;
    hsize  = s;
    hprot  = p;
  endtask

  task automatic end_addr();
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic test_reset();
    n_cmp++; if ({hready, hresp, psel, penable, pwrite} !== 5'b10000) begin n_err++;
      $display("FAIL reset_ctl got %b want 10000", {hready, hresp, psel, penable, pwrite}); end
    n_cmp++; if ({hrdata, paddr, pwdata, pstrb, pprot} !== 103'd0) begin n_err++;
      $display("FAIL reset_data got %h want 0", {hrdata, paddr, pwdata, pstrb, pprot}); end
    n_cmp++; if ({hready_to, hresp_to, psel_to, penable_to} !== 4'b1000) begin n_err++;
      $display("FAIL reset_to_ctl got %b want 1000", {hready_to, hresp_to, psel_to, penable_to}); end
  endtask

  task automatic test_idle_busy();
    logic [1:0] tr [2];
    tr[0] = 2'b00;
    tr[1] = 2'b01;
    for (int i = 0; i < 2; i++) begin
      hsel = 1'b1; htrans = tr[i]; haddr = 32'h10; hwrite = 1'b0; hsize = 3'd2;
      step();
      n_cmp++; if ({hready, hresp, psel} !== 3'b100) begin n_err++;
        $display("FAIL idle_busy_%0d got %b want 100", i, {hready, hresp, psel}); end
    end
    start_xfer(32'h10, 1'b0, 3'd2, 4'b0000);
    hreadym = 1'b0;
    step();
    n_cmp++; if ({hready, psel} !== 2'b10) begin n_err++;
      $display("FAIL hreadym_low got %b want 10", {hready, psel}); end
    hreadym = 1'b1;
    end_addr();
    step();
  endtask

  task automatic test_read();
    prdata = 32'hDEADBEEF; pready = 1'b1; pslverr = 1'b0;
    start_xfer(32'h40, 1'b0, 3'd2, 4'b0001);
    step(); end_addr();
    n_cmp++; if ({psel, penable, hready} !== 3'b100) begin n_err++;
      $display("FAIL rd_t1_ctl got %b want 100", {psel, penable, hready}); end
    n_cmp++; if ({paddr, pwrite, pstrb, pprot} !== {32'h40, 1'b0, 4'b0000, 3'b000}) begin n_err++;
      $display("FAIL rd_t1_apb got %h want %h", {paddr, pwrite, pstrb, pprot}, {32'h40, 1'b0, 4'b0000, 3'b000}); end
    step();
    n_cmp++; if ({psel, penable, hready} !== 3'b110) begin n_err++;
      $display("FAIL rd_t2_ctl got %b want 110", {psel, penable, hready}); end
    step();
    n_cmp++; if ({psel, penable, hready, hresp} !== 4'b0010) begin n_err++;
      $display("FAIL rd_t3_ctl got %b want 0010", {psel, penable, hready, hresp}); end
    n_cmp++; if (hrdata !== 32'hDEADBEEF) begin n_err++;
      $display("FAIL rd_t3_hrdata got %h want deadbeef", hrdata); end
    step();
  endtask

  task automatic test_write_byte();
    pready = 1'b1; pslverr = 1'b0;
    start_xfer(32'h103, 1'b1, 3'd0, 4'b0011);
    step(); end_addr(); hwdata = 32'h000000A5;
    n_cmp++; if ({psel, hready} !== 2'b00) begin n_err++;
      $display("FAIL wr_t1_ctl got %b want 00", {psel, hready}); end
    n_cmp++; if ({paddr, pwrite, pstrb, pprot} !== {32'h103, 1'b1, 4'b1000, 3'b001}) begin n_err++;
      $display("FAIL wr_t1_apb got %h want %h", {paddr, pwrite, pstrb, pprot}, {32'h103, 1'b1, 4'b1000, 3'b001}); end
    step();
    n_cmp++; if ({psel, penable, hready} !== 3'b100) begin n_err++;
      $display("FAIL wr_t2_ctl got %b want 100", {psel, penable, hready}); end
    n_cmp++; if (pwdata !== 32'h000000A5) begin n_err++;
      $display("FAIL wr_t2_pwdata got %h want 000000a5", pwdata); end
    step();
    n_cmp++; if ({psel, penable, hready} !== 3'b110) begin n_err++;
      $display("FAIL wr_t3_ctl got %b want 110", {psel, penable, hready}); end
    step();
    n_cmp++; if ({psel, penable, hready, hresp} !== 4'b0010) begin n_err++;
      $display("FAIL wr_t4_ctl got %b want 0010", {psel, penable, hready, hresp}); end
    n_cmp++; if ({paddr, pstrb} !== {32'h103, 4'b1000}) begin n_err++;
      $display("FAIL wr_t4_hold got %h want %h", {paddr, pstrb}, {32'h103, 4'b1000}); end
    step();
  endtask

  task automatic test_slverr();
    prdata = 32'h12345678; pready = 1'b0; pslverr = 1'b0;
    start_xfer(32'h44, 1'b0, 3'd2, 4'b0000);
    step(); end_addr();
    n_cmp++; if ({psel, penable, pprot} !== 5'b10100) begin n_err++;
      $display("FAIL err_t1 got %b want 10100", {psel, penable, pprot}); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if ({psel, penable, hready, hresp} !== 4'b1100) begin n_err++;
        $display("FAIL err_access_%0d got %b want 1100", i, {psel, penable, hready, hresp}); end
      if (i == 3) begin pready = 1'b1; pslverr = 1'b1; end
    end
    step(); pready = 1'b0; pslverr = 1'b0;
    n_cmp++; if ({psel, penable, hready, hresp} !== 4'b0001) begin n_err++;
      $display("FAIL err_err1 got %b want 0001", {psel, penable, hready, hresp}); end
    step();
    n_cmp++; if ({hready, hresp} !== 2'b11) begin n_err++;
      $display("FAIL err_err2 got %b want 11", {hready, hresp}); end
    n_cmp++; if (hrdata !== 32'hDEADBEEF) begin n_err++;
      $display("FAIL err_hrdata got %h want deadbeef", hrdata); end
    step();
    n_cmp++; if ({hready, hresp} !== 2'b10) begin n_err++;
      $display("FAIL err_after got %b want 10", {hready, hresp}); end
  endtask

  task automatic test_misaligned();
    logic [31:0] a [2];
    logic [2:0]  s [2];
    logic        w [2];
    a[0] = 32'h201; s[0] = 3'd1; w[0] = 1'b1;
    a[1] = 32'h200; s[1] = 3'd3; w[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_xfer(a[i], w[i], s[i], 4'b0000);
      step(); end_addr();
      n_cmp++; if ({psel, hready, hresp} !== 3'b001) begin n_err++;
        $display("FAIL mis_%0d_err1 got %b want 001", i, {psel, hready, hresp}); end
      step();
      n_cmp++; if ({psel, hready, hresp} !== 3'b011) begin n_err++;
        $display("FAIL mis_%0d_err2 got %b want 011", i, {psel, hready, hresp}); end
      step();
    end
  endtask

  task automatic test_timeout();
    pready = 1'b0; pslverr = 1'b0;
    hsel = 1'b0; hsel_to = 1'b1; htrans = 2'b10; haddr = 32'h80; hwrite = 1'b0; hsize = 3'd2;
    step(); hsel_to = 1'b0; htrans = 2'b00;
    n_cmp++; if ({psel_to, penable_to} !== 2'b10) begin n_err++;
      $display("FAIL to_setup got %b want 10", {psel_to, penable_to}); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if ({psel_to, penable_to} !== 2'b11) begin n_err++;
        $display("FAIL to_access_%0d got %b want 11", i, {psel_to, penable_to}); end
    end
    step();
    n_cmp++; if ({psel_to, penable_to, hready_to, hresp_to} !== 4'b0001) begin n_err++;
      $display("FAIL to_err1 got %b want 0001", {psel_to, penable_to, hready_to, hresp_to}); end
    step();
    n_cmp++; if ({hready_to, hresp_to} !== 2'b11) begin n_err++;
      $display("FAIL to_err2 got %b want 11", {hready_to, hresp_to}); end
    n_cmp++; if (psel !== 1'b0) begin n_err++;
      $display("FAIL to_main_idle got %b want 0", psel); end
    step();
  endtask

  task automatic test_back_to_back();
    prdata = 32'hCAFEF00D; pready = 1'b1; pslverr = 1'b0;
    start_xfer(32'h300, 1'b1, 3'd2, 4'b0000);
    step(); end_addr(); hwdata = 32'h11223344;
    step();
    n_cmp++; if ({psel, pstrb, pwdata} !== {1'b1, 4'b1111, 32'h11223344}) begin n_err++;
      $display("FAIL b2b_wr_setup got %h want %h", {psel, pstrb, pwdata}, {1'b1, 4'b1111, 32'h11223344}); end
    step();
    step();
    n_cmp++; if ({psel, hready, hresp} !== 3'b010) begin n_err++;
      $display("FAIL b2b_done got %b want 010", {psel, hready, hresp}); end
    start_xfer(32'h304, 1'b0, 3'd2, 4'b0000);
    step(); end_addr();
    n_cmp++; if ({psel, penable, hready, pwrite, pstrb} !== 8'b1000_0000) begin n_err++;
      $display("FAIL b2b_rd_setup got %b want 10000000", {psel, penable, hready, pwrite, pstrb}); end
    n_cmp++; if (paddr !== 32'h304) begin n_err++;
      $display("FAIL b2b_rd_paddr got %h want 00000304", paddr); end
    step();
    step();
    n_cmp++; if ({hready, hresp, hrdata} !== {2'b10, 32'hCAFEF00D}) begin n_err++;
      $display("FAIL b2b_rd_done got %h want %h", {hready, hresp, hrdata}, {2'b10, 32'hCAFEF00D}); end
    step();
  endtask

  task automatic test_reset_mid();
    pready = 1'b0; pslverr = 1'b0;
    start_xfer(32'h48, 1'b0, 3'd2, 4'b0000);
    step(); end_addr();
    step();
    n_cmp++; if ({psel, penable} !== 2'b11) begin n_err++;
      $display("FAIL rst_pre got %b want 11", {psel, penable}); end
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if ({psel, penable, hready, hresp} !== 4'b0010) begin n_err++;
      $display("FAIL rst_async got %b want 0010", {psel, penable, hready, hresp}); end
    n_cmp++; if (hrdata !== 32'h0) begin n_err++;
      $display("FAIL rst_hrdata got %h want 0", hrdata); end
    #3 resetn = 1'b1;
    step();
    prdata = 32'h5A5A0001; pready = 1'b1;
    start_xfer(32'h4C, 1'b0, 3'd2, 4'b0000);
    step(); end_addr();
    n_cmp++; if ({psel, penable, paddr} !== {2'b10, 32'h4C}) begin n_err++;
      $display("FAIL rst_after_setup got %h want %h", {psel, penable, paddr}, {2'b10, 32'h4C}); end
    step();
    step();
    n_cmp++; if ({hready, hresp, hrdata} !== {2'b10, 32'h5A5A0001}) begin n_err++;
      $display("FAIL rst_after_done got %h want %h", {hready, hresp, hrdata}, {2'b10, 32'h5A5A0001}); end
    step();
  endtask

  initial begin
    resetn = 1'b0; hsel = 1'b0; hsel_to = 1'b0; haddr = '0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd0; hprot = 4'b0000; hreadym = 1'b1; hwdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) step();
    test_reset();
    resetn = 1'b1;
    step();
    test_idle_busy();
    test_read();
    test_write_byte();
    test_slverr();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
